// File: rtl/if_stage.sv
// rtl/if_stage.sv - Instruction fetch stage: pre-IF address generation and IF register with stall buffer
module if_stage #(
    parameter logic [31:0] RESET_PC           = 32'h1c000000,
    parameter int          IF_TO_ID_BUS_WIDTH = 64,
    parameter int          ID_TO_IF_BUS_WIDTH = 33
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          id_allow_in,
    output logic                          if_to_id_valid,
    output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
    input  logic [ID_TO_IF_BUS_WIDTH-1:0] id_to_if_bus,
    output logic                          inst_sram_en,
    output logic [3:0]                    inst_sram_we,
    output logic [31:0]                   inst_sram_addr,
    output logic [31:0]                   inst_sram_wdata,
    input  logic [31:0]                   inst_sram_rdata
);
    // Encoding is exactly {if_valid, buf_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        LIVE  = 2'b10,
        HELD  = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;

    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] nextpc;
    logic [31:0] inst;
    logic        if_valid;
    logic        buf_valid;
    logic        if_ready_go;
    logic        flush;
    logic        if_allow_in;

    assign br_taken  = id_to_if_bus[ID_TO_IF_BUS_WIDTH-1];
    assign br_target = id_to_if_bus[31:0];

    assign if_valid    = (state_q != EMPTY);
    assign buf_valid   = (state_q == HELD);
    assign if_ready_go = 1'b1;
    assign flush       = br_taken;
    assign if_allow_in = !if_valid || (if_ready_go && id_allow_in) || flush;

    assign nextpc = br_taken ? br_target : (if_pc_q + 32'd4);

    assign inst_sram_en    = resetn && if_allow_in;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_wdata = 32'b0;

    // The SRAM output is only trustworthy for one cycle, so a stalled instruction is served from the buffer.
    assign inst           = buf_valid ? inst_buf_q : inst_sram_rdata;
    assign if_to_id_valid = if_valid && if_ready_go && !flush;
    assign if_to_id_bus   = {if_pc_q, inst};

    always_comb begin
        state_d    = state_q;
        if_pc_d    = if_pc_q;
        inst_buf_d = inst_buf_q;
        if (if_allow_in) begin
            state_d = LIVE;
            if_pc_d = nextpc;
        end else if (state_q == LIVE) begin
            // if_allow_in=0 already implies a valid IF instruction and no flush.
            state_d    = HELD;
            inst_buf_d = inst_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= EMPTY;
            if_pc_q    <= RESET_PC - 32'd4;
            inst_buf_q <= 32'b0;
        end else begin
            state_q    <= state_d;
            if_pc_q    <= if_pc_d;
            inst_buf_q <= inst_buf_d;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - Scoreboard testbench for if_stage with directed and randomized fetch/branch/stall traffic
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_allow_in;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_bus;
    logic [32:0] id_to_if_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .id_allow_in    (id_allow_in),
        .if_to_id_valid (if_to_id_valid),
        .if_to_id_bus   (if_to_id_bus),
        .id_to_if_bus   (id_to_if_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata)
    );

    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        logic        valid;
    } cyc_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ho_t;

    cyc_t cyc_q[$];
    ho_t  ho_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference: the PC held in IF and whether it holds anything; instruction memory is a fixed hash.
    logic        m_valid;
    logic [31:0] m_pc;
    logic        cap_en;
    logic [31:0] cap_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h0badf00d;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic a, input logic b, input logic [31:0] t);
        cyc_t c;
        logic accept;
        // SRAM returns the word requested last cycle; otherwise its output drifts.
        if (cap_en)
            inst_sram_rdata = mem_word(cap_addr);
        else if ($urandom_range(0, 1) == 0)
            inst_sram_rdata = 32'hdeadbeef;
        else
            inst_sram_rdata = $urandom;
        resetn       = r;
        id_allow_in  = a;
        id_to_if_bus = {b, t};
        if (!r) begin
            accept  = 1'b0;
            c.en    = 1'b0;
            c.addr  = 32'h0;
            c.valid = 1'b0;
        end else begin
            accept  = !m_valid || a || b;
            c.en    = accept;
            c.addr  = b ? t : (m_pc + 32'd4);
            c.valid = m_valid && !b;
            if (c.valid && a) ho_q.push_back('{pc: m_pc, inst: mem_word(m_pc)});
        end
        cyc_q.push_back(c);
        @(negedge clk);
        cap_en   = inst_sram_en;
        cap_addr = inst_sram_addr;
        @(posedge clk);
        if (!r) begin
            m_valid = 1'b0;
            m_pc    = RESET_PC - 32'd4;
        end else if (accept) begin
            m_valid = 1'b1;
            m_pc    = c.addr;
        end
        #1;
    endtask

    initial begin : monitor
        cyc_t c;
        ho_t  h;
        forever begin
            @(negedge clk);
            if (cyc_q.size() != 0) begin
                c = cyc_q.pop_front();
                check("sram_en", {63'b0, inst_sram_en}, {63'b0, c.en});
                if (c.en) check("sram_addr", {32'b0, inst_sram_addr}, {32'b0, c.addr});
                check("to_id_valid", {63'b0, if_to_id_valid}, {63'b0, c.valid});
                check("sram_we_wdata", {28'b0, inst_sram_we, inst_sram_wdata}, 64'h0);
                if (if_to_id_valid && id_allow_in) begin
                    if (ho_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_handoff actual=%h required=none", if_to_id_bus);
                    end else begin
                        h = ho_q.pop_front();
                        check("handoff_pc", {32'b0, if_to_id_bus[63:32]}, {32'b0, h.pc});
                        check("handoff_inst", {32'b0, if_to_id_bus[31:0]}, {32'b0, h.inst});
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        resetn          = 1'b0;
        id_allow_in     = 1'b0;
        id_to_if_bus    = '0;
        inst_sram_rdata = '0;
        m_valid         = 1'b0;
        m_pc            = RESET_PC - 32'd4;
        cap_en          = 1'b0;
        cap_addr        = '0;
        @(posedge clk);
        #1;

        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
        // Stall at 1c000008 while the SRAM output drifts.
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h1c000100);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        // Branch held for two cycles while the buffer is in use.
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) step(1'b1, 1'b0, 1'b1, 32'h1c000200);
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'hfffffffc);
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
        // Reset arriving while an instruction is held.
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);

        for (int i = 0; i < 600; i++) begin
            tgt = $urandom & 32'hfffffffc;
            if ($urandom_range(0, 9) == 0) tgt = 32'hfffffff8;
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 99) < 12), tgt);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check("handoff_queue_drained", 64'(ho_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
